// File: rtl/freq_sequencer.sv
// freq_sequencer: queues {freq, dur} note requests and plays them back-to-back on sample ticks
module freq_sequencer #(
  parameter int TICK_DIV   = 2000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk96M,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [14:0] req_freq,
  input  logic [15:0] req_dur,
  input  logic        abort,
  output logic [14:0] freq,
  output logic        gate,
  output logic        phase_rst,
  output logic        tick,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t      state;
  logic [15:0] cnt, remain;
  logic [30:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic en, push, pop, empty, full;
  assign tick = cnt == 16'(TICK_DIV - 1);
  assign empty = count == '0;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  // en holds req_ready low until the first edge after reset release
  assign req_ready = en & ~full & ~abort;
  assign push = req_valid & req_ready;
  assign pop = tick & ~empty & ~abort & (state == IDLE | remain == 16'd1);
  assign busy = state == PLAY | ~empty;
  always_ff @(posedge clk96M or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
  always_ff @(posedge clk96M)
    if (push) mem[wp] <= {req_freq, req_dur == 16'd0 ? 16'd1 : req_dur};
  always_ff @(posedge clk96M or posedge reset)
    if (reset) begin
      en <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      state <= IDLE;
      remain <= '0;
      freq <= '0;
      gate <= 1'b0;
      phase_rst <= 1'b0;
    end else begin
      en <= 1'b1;
      phase_rst <= 1'b0;
      if (abort) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
        state <= IDLE;
        freq <= '0;
        gate <= 1'b0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (pop) begin
          freq <= mem[rp][30:16];
          remain <= mem[rp][15:0];
          gate <= 1'b1;
          phase_rst <= 1'b1;
          state <= PLAY;
        end else if (tick && state == PLAY) begin
          if (remain > 16'd1) remain <= remain - 16'd1;
          else begin
            state <= IDLE;
            freq <= '0;
            gate <= 1'b0;
          end
        end
      end
    end
endmodule

// File: tb/tb_freq_sequencer.sv
// tb_freq_sequencer: vector table for a single note plus directed multi-cycle sequences
module tb_freq_sequencer;
  logic clk96M = 1'b0, reset = 1'b1, req_valid = 1'b0, abort = 1'b0;
  logic [14:0] req_freq = '0;
  logic [15:0] req_dur = '0;
  logic req_ready, gate, phase_rst, tick, busy;
  logic [14:0] freq;
  int passed = 0, total = 0;

  freq_sequencer #(.TICK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk96M(clk96M), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_freq(req_freq), .req_dur(req_dur), .abort(abort), .freq(freq), .gate(gate),
    .phase_rst(phase_rst), .tick(tick), .busy(busy)
  );

  always #5 clk96M = ~clk96M;

  typedef struct {
    logic v; logic [14:0] f; logic [15:0] d; logic a;
    logic rdy; logic [14:0] ef; logic eg, ep, et, eb;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic v, logic [14:0] f, logic [15:0] d, logic a,
                              logic rdy, logic [14:0] ef, logic eg, logic ep, logic et, logic eb);
    tbl.push_back('{v, f, d, a, rdy, ef, eg, ep, et, eb});
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk96M);
    #2;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!tick && n < 16) begin step(); #1; n++; end
    chk("tick seen", int'(tick), 1);
  endtask

  task automatic wait_prst(input string name);
    int n = 0;
    while (!phase_rst && n < 64) begin step(); #1; n++; end
    chk(name, int'(phase_rst), 1);
  endtask

  task automatic measure(input logic [14:0] f, output int n);
    n = 0;
    while (freq == f && gate && n < 100) begin step(); #1; n++; end
  endtask

  task automatic quiet(input string name, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      step(); #1;
      if (gate || busy || phase_rst || freq != 0) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [14:0] fs [5];
    logic [15:0] ds [5];
    int n, k, blocked;
    logic acc;
    // single note {440,3}; step index = cycles since reset release, tick at index%4==3
    add(0, 0,   0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 440, 3, 0, 1, 0,   0, 0, 0, 0);
    add(0, 0,   0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0,   0, 0, 1, 0,   0, 0, 1, 1);
    add(0, 0,   0, 0, 1, 440, 1, 1, 0, 1);
    for (int s = 5; s <= 15; s++) add(0, 0, 0, 0, 1, 440, 1, 0, s % 4 == 3, 1);
    add(0, 0,   0, 0, 1, 0,   0, 0, 0, 0);

    #1;
    chk("reset ready", int'(req_ready), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset tick", int'(tick), 0);
    repeat (3) @(posedge clk96M);
    #2 reset = 1'b0;
    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_freq = tbl[i].f; req_dur = tbl[i].d; abort = tbl[i].a;
      #1;
      chk($sformatf("A%0d ready", i), int'(req_ready), int'(tbl[i].rdy));
      chk($sformatf("A%0d freq", i), int'(freq), int'(tbl[i].ef));
      chk($sformatf("A%0d gate", i), int'(gate), int'(tbl[i].eg));
      chk($sformatf("A%0d phase_rst", i), int'(phase_rst), int'(tbl[i].ep));
      chk($sformatf("A%0d tick", i), int'(tick), int'(tbl[i].et));
      chk($sformatf("A%0d busy", i), int'(busy), int'(tbl[i].eb));
      step();
    end

    // back-to-back notes with no gate gap
    req_valid = 1; req_freq = 440; req_dur = 2; #1;
    chk("B ready1", int'(req_ready), 1);
    step(); req_freq = 600; #1;
    chk("B ready2", int'(req_ready), 1);
    step(); req_valid = 0; #1;
    wait_prst("B start");
    chk("B freq1", int'(freq), 440);
    measure(440, n);
    chk("B 440 length", n, 8);
    chk("B prst2", int'(phase_rst), 1);
    chk("B freq2", int'(freq), 600);
    chk("B gate2", int'(gate), 1);
    measure(600, n);
    chk("B 600 length", n, 8);
    chk("B end freq", int'(freq), 0);
    chk("B end gate", int'(gate), 0);
    chk("B end busy", int'(busy), 0);

    // queue fills during a long note; 5th request waits for the pop
    fs = '{101, 102, 103, 104, 105};
    ds = '{1, 0, 2, 1, 1};
    req_valid = 1; req_freq = 100; req_dur = 3;
    step(); req_valid = 0; #1;
    wait_prst("C start");
    k = 0; blocked = 0; n = 0;
    req_valid = 1;
    while (k < 5 && n < 100) begin
      req_freq = fs[k]; req_dur = ds[k]; #1;
      acc = req_ready;
      if (k == 4 && !acc) blocked++;
      if (k == 4 && acc) begin
        chk("C 5th ready after pop", int'(phase_rst), 1);
        chk("C first queued freq", int'(freq), 101);
      end
      step();
      if (acc) k++;
      n++;
    end
    req_valid = 0; #1;
    chk("C pushes done", k, 5);
    chk("C 5th stall cycles", blocked, 8);
    measure(101, n);
    chk("C 101 remainder", n, 3);
    for (int j = 1; j < 5; j++) begin
      chk($sformatf("C%0d prst", j), int'(phase_rst), 1);
      chk($sformatf("C%0d freq", j), int'(freq), int'(fs[j]));
      measure(fs[j], n);
      chk($sformatf("C%0d length", j), n, j == 2 ? 8 : 4);
    end
    chk("C end gate", int'(gate), 0);
    chk("C end busy", int'(busy), 0);

    // abort on a tick during a note with two queued
    wait_tick();
    step(); req_valid = 1; req_freq = 200; req_dur = 5;
    step(); req_freq = 201; req_dur = 1;
    step(); req_freq = 202;
    step(); req_valid = 0; #1;
    wait_prst("D start");
    chk("D freq", int'(freq), 200);
    step(); #1;
    wait_tick();
    abort = 1; #1;
    chk("D ready under abort", int'(req_ready), 0);
    step(); abort = 0; #1;
    chk("D freq after abort", int'(freq), 0);
    chk("D gate after abort", int'(gate), 0);
    chk("D busy after abort", int'(busy), 0);
    chk("D prst after abort", int'(phase_rst), 0);
    quiet("D no later note", 16);

    // async reset mid-note with three queued
    wait_tick();
    step(); req_valid = 1; req_freq = 300; req_dur = 5;
    step(); req_freq = 301; req_dur = 1;
    step(); req_freq = 302;
    step(); req_freq = 303;
    step(); req_valid = 0; #1;
    wait_prst("E start");
    chk("E freq", int'(freq), 300);
    step(); step(); #1;
    reset = 1; #1;
    chk("E async freq", int'(freq), 0);
    chk("E async gate", int'(gate), 0);
    chk("E async busy", int'(busy), 0);
    chk("E async ready", int'(req_ready), 0);
    chk("E async tick", int'(tick), 0);
    repeat (2) step();
    reset = 0; #1;
    chk("E ready at release", int'(req_ready), 0);
    chk("E tick s0", int'(tick), 0);
    for (int s = 1; s <= 3; s++) begin
      step(); #1;
      chk($sformatf("E tick s%0d", s), int'(tick), s == 3);
      if (s == 1) chk("E ready first edge", int'(req_ready), 1);
    end
    quiet("E no residual notes", 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/freq_sequencer.md
FREQ_SEQUENCER -- requirements
Module: freq_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 2000, clk96M cycles per sample tick (96 MHz / 2000 = 48 kHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, note-request queue depth; power of two, 2..16.
REQ-003 clk96M  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  note request present.
REQ-006 req_ready  output  1  queue can accept a request.
REQ-007 req_freq  input  15  note frequency in Hz, passed unchanged to the sine generator.
REQ-008 req_dur  input  16  note duration in sample ticks.
REQ-009 abort  input  1  synchronous flush: drops the queue and silences output.
REQ-010 freq  output  15  frequency word driving the sine generator's freq port.
REQ-011 gate  output  1  high while a note plays.
REQ-012 phase_rst  output  1  one-cycle pulse at each note start; resets the sine generator phase.
REQ-013 tick  output  1  one-cycle sample strobe.
REQ-014 busy  output  1  high when state is PLAY or the queue is non-empty.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high exactly in the cycle the count equals TICK_DIV-1.
REQ-016 Queue SHALL be a FIFO of {req_freq, req_dur}; req_ready = not full; push occurs when req_valid and req_ready are both high.
REQ-017 A request with req_dur = 0 SHALL be stored and played as req_dur = 1.
REQ-018 There SHALL be no empty-queue bypass: an entry pushed in cycle N is poppable no earlier than cycle N+1.
REQ-019 Simultaneous push and pop in one cycle SHALL leave the occupancy unchanged.
REQ-020 The state machine SHALL have two states, IDLE and PLAY, with a 16-bit remain counter.
REQ-021 IDLE, tick high, queue non-empty: pop head; next cycle freq = head freq, remain = head dur, gate = 1, phase_rst = 1; go to PLAY.
REQ-022 IDLE with the queue empty: freq = 0 and gate = 0 are held.
REQ-023 PLAY, tick high, remain > 1: decrement remain; no other change.
REQ-024 PLAY, tick high, remain = 1, queue non-empty: pop and load the next note back-to-back (gate stays 1, phase_rst pulses, freq updates); stay in PLAY.
REQ-025 PLAY, tick high, remain = 1, queue empty: next cycle freq = 0, gate = 0; go to IDLE.
REQ-026 freq and gate SHALL change only in the cycle after a tick, except on abort or reset.
REQ-027 phase_rst SHALL be high for exactly one cycle per note start and low otherwise.
REQ-028 A note of duration D SHALL hold gate high for exactly D ticks (D x TICK_DIV cycles).
REQ-029 abort high in any cycle: next cycle queue empty, state IDLE, freq = 0, gate = 0, phase_rst = 0.
REQ-030 While abort is high, no push SHALL occur (req_ready = 0). abort takes priority over a simultaneous tick or pop.
REQ-031 The tick counter SHALL be unaffected by abort.

Reset
REQ-032 While reset is high: tick counter = 0, queue empty, state IDLE, freq = 0, gate = 0, phase_rst = 0, tick = 0, busy = 0, req_ready = 0.
REQ-033 After reset deasserts, req_ready SHALL go high from the first clock edge. The first tick SHALL occur TICK_DIV cycles after reset release.
REQ-034 Reset asserted mid-note SHALL silence output immediately (asynchronously) and discard all queued notes.

Verification (TICK_DIV = 4, FIFO_DEPTH = 4)
REQ-035 Push {440, 3} while idle -> next tick: freq = 440, gate = 1, phase_rst pulses once. Gate high for 12 cycles, then freq = 0, gate = 0, busy = 0.
REQ-036 Push {440, 2} then {600, 2} -> freq 440 for 8 cycles, then 600 for 8 cycles with no gate gap. Two phase_rst pulses, 8 cycles apart.
REQ-037 Push 5 requests with no tick -> first 4 accepted. req_ready = 0 on the 5th until the first pop; the 5th is accepted the cycle after that pop.
REQ-038 Push {1000, 0} -> plays for exactly 1 tick (4 cycles).
REQ-039 abort during PLAY with 2 queued -> next cycle freq = 0, gate = 0, busy = 0. Later ticks start no note.
REQ-040 Assert reset mid-note with 3 queued -> outputs go to 0 without waiting for a clock edge. After release: req_ready = 1, first tick TICK_DIV cycles later, no residual notes.
